// File: rtl/jt51_wrqueue.sv
// jt51_wrqueue: buffered host write queue that replays (chip, addr, data) entries as
// address/data strobes on a shared jt51 bus. Define JT51_WRQ_TIMEOUT_EN for busy-wait timeout.
module jt51_wrqueue #(
    parameter int NCHIP   = 2,
    parameter int CW      = 1,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen_p1,
    input  logic             host_we,
    input  logic [CW-1:0]    host_chip,
    input  logic [7:0]       host_addr,
    input  logic [7:0]       host_data,
    output logic             host_ready,
    input  logic             flush,
    output logic [AW:0]      level,
    output logic             idle,
    input  logic [NCHIP-1:0] chip_busy,
    output logic [NCHIP-1:0] cs_n,
    output logic             wr_n,
    output logic             a0,
    output logic [7:0]       din,
    output logic             err
);

    localparam int GW = $clog2(GUARD + 2);

    typedef struct packed {
        logic [CW-1:0] chip;
        logic [7:0]    addr;
        logic [7:0]    data;
    } entry_t;

    typedef enum logic [2:0] {IDLE, ASTB, AWAIT, DSTB, DWAIT} state_t;

    state_t           state;
    entry_t           mem [DEPTH];
    entry_t           head;
    entry_t           work;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_n;
    logic [GW-1:0]    gcnt;
    logic [NCHIP-1:0] cache_valid;
    logic [7:0]       cache_addr [NCHIP];

    logic head_ok, cache_hit, load, skip;
    logic in_wait, guard_done, wait_done, abort;
    logic push, pop, keep, idle_state_n;

    assign head         = mem[rd_ptr];
    assign head_ok      = int'(head.chip) < NCHIP;
    assign cache_hit    = cache_valid[head.chip] && (cache_addr[head.chip] == head.addr);
    assign load         = (state == IDLE) && (level != '0) && head_ok;
    assign skip         = (state == IDLE) && (level != '0) && !head_ok;
    assign in_wait      = (state == AWAIT) || (state == DWAIT);
    assign guard_done   = (gcnt == GW'(GUARD));
    assign wait_done    = in_wait && guard_done && !chip_busy[work.chip];
    assign push         = host_we && host_ready && !flush;
    assign pop          = skip || ((state == DWAIT) && wait_done) || abort;
    // On flush only the entry already in the work register survives, until it pops.
    assign keep         = ((state != IDLE) || (level != '0)) && !pop;
    assign idle_state_n = ((state == IDLE) && !load) || pop;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        level_n = level;
        if (flush)
            level_n = (AW+1)'(keep);
        else if (push && !pop)
            level_n = level + (AW+1)'(1);
        else if (!push && pop)
            level_n = level - (AW+1)'(1);
    end

    // NOTE: storage arrays carry no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= entry_t'{chip: host_chip, addr: host_addr, data: host_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            host_ready <= 1'b1;
            idle       <= 1'b1;
        end else begin
            if (flush) begin
                rd_ptr <= rd_ptr + AW'(pop);
                wr_ptr <= rd_ptr + AW'(pop) + AW'(keep);
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            level      <= level_n;
            host_ready <= (level_n != (AW+1)'(DEPTH));
            idle       <= (level_n == '0) && idle_state_n;
        end
    end

`ifdef JT51_WRQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    assign abort = in_wait && guard_done && chip_busy[work.chip] && cen_p1
                   && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            if (!in_wait)
                tcnt <= '0;
            else if (guard_done && chip_busy[work.chip] && cen_p1)
                tcnt <= tcnt + TW'(1);
            if (abort)
                err <= 1'b1;
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            gcnt        <= '0;
            cs_n        <= '1;
            wr_n        <= 1'b1;
            a0          <= 1'b0;
            din         <= '0;
            cache_valid <= '0;
        end else begin
            if (flush)
                cache_valid <= '0;
            case (state)
                IDLE: begin
                    if (load) begin
                        work <= head;
                        cs_n <= ~(NCHIP'(1) << head.chip);
                        wr_n <= 1'b0;
                        if (cache_hit) begin
                            state <= DSTB;
                            a0    <= 1'b1;
                            din   <= head.data;
                        end else begin
                            state <= ASTB;
                            a0    <= 1'b0;
                            din   <= head.addr;
                        end
                    end
                end
                ASTB, DSTB: begin
                    // The chip latches on the first cen_p1 seen with wr_n low.
                    if (cen_p1) begin
                        cs_n <= '1;
                        wr_n <= 1'b1;
                        gcnt <= '0;
                        if (state == ASTB) begin
                            state                   <= AWAIT;
                            cache_valid[work.chip]  <= 1'b1;
                        end else begin
                            state <= DWAIT;
                        end
                    end
                end
                AWAIT, DWAIT: begin
                    if (!guard_done && cen_p1)
                        gcnt <= gcnt + GW'(1);
                    if (abort) begin
                        state                  <= IDLE;
                        cache_valid[work.chip] <= 1'b0;
                    end else if (wait_done) begin
                        if (state == AWAIT) begin
                            state <= DSTB;
                            a0    <= 1'b1;
                            din   <= work.data;
                            cs_n  <= ~(NCHIP'(1) << work.chip);
                            wr_n  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ASTB) && cen_p1)
            cache_addr[work.chip] <= work.addr;
    end

endmodule

// File: tb/tb_jt51_wrqueue.sv
// tb_jt51_wrqueue: random and directed stimulus; an entry-level model predicts every bus write.
module tb_jt51_wrqueue;

    localparam int NCHIP = 2;
    localparam int CW    = 1;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             rst_n;
    logic             cen_p1;
    logic             host_we;
    logic [CW-1:0]    host_chip;
    logic [7:0]       host_addr;
    logic [7:0]       host_data;
    logic             host_ready;
    logic             flush;
    logic [AW:0]      level;
    logic             idle;
    logic [NCHIP-1:0] chip_busy;
    logic [NCHIP-1:0] cs_n;
    logic             wr_n;
    logic             a0;
    logic [7:0]       din;
    logic             err;

    jt51_wrqueue #(.NCHIP(NCHIP), .CW(CW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cen_p1(cen_p1),
        .host_we(host_we), .host_chip(host_chip), .host_addr(host_addr), .host_data(host_data),
        .host_ready(host_ready), .flush(flush), .level(level), .idle(idle),
        .chip_busy(chip_busy), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din), .err(err)
    );

    typedef struct {
        int         chip;
        logic [7:0] addr;
        logic [7:0] data;
    } ent_t;

    // Model: accepted entries not yet fully seen on the bus, phase within the head entry,
    // and the address each chip currently holds.
    ent_t             q[$];
    bit               phase;
    bit   [NCHIP-1:0] cvalid;
    logic [7:0]       caddr [NCHIP];

    int n_cmp;
    int n_bad;
    int n_writes;

    ent_t             mon_e;
    logic [NCHIP+8:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cen_p1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cen_p1 = ~cen_p1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // A chip latches a write whenever cen_p1 is high with its strobe low.
    always @(negedge clk) begin
        if (rst_n && !wr_n && cen_p1) begin
            n_writes++;
            check("write_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                mon_e = q[0];
                if (!phase && !(cvalid[mon_e.chip] && caddr[mon_e.chip] == mon_e.addr)) begin
                    mon_exp = {~(NCHIP'(1) << mon_e.chip), 1'b0, mon_e.addr};
                    cvalid[mon_e.chip] = 1'b1;
                    caddr[mon_e.chip]  = mon_e.addr;
                    phase = 1'b1;
                end else begin
                    mon_exp = {~(NCHIP'(1) << mon_e.chip), 1'b1, mon_e.data};
                    void'(q.pop_front());
                    phase = 1'b0;
                end
                check("bus_write", {cs_n, a0, din}, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int chip, input logic [7:0] addr, input logic [7:0] data,
                        input bit accept);
        host_we   = 1'b1;
        host_chip = CW'(chip);
        host_addr = addr;
        host_data = data;
        tick();
        host_we = 1'b0;
        if (accept)
            q.push_back('{chip, addr, data});
    endtask

    task automatic model_clear();
        q.delete();
        phase  = 1'b0;
        cvalid = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!idle && n < 3000) begin
            tick();
            n++;
        end
        check(tag, idle, 1);
        check({tag, "_drained"}, q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cs_n"}, cs_n, {NCHIP{1'b1}});
        check({tag, "_wr_n"}, wr_n, 1);
        check({tag, "_a0"}, a0, 0);
        check({tag, "_din"}, din, 0);
        check({tag, "_ready"}, host_ready, 1);
        check({tag, "_level"}, level, 0);
        check({tag, "_idle"}, idle, 1);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int        w0;
        int        n;
        ent_t      h;
        logic [7:0] addr_set [3];

        n_cmp = 0; n_bad = 0; n_writes = 0;
        rst_n = 1'b0; host_we = 1'b0; host_chip = '0; host_addr = '0; host_data = '0;
        flush = 1'b0; chip_busy = '0;
        model_clear();
        addr_set[0] = 8'h20; addr_set[1] = 8'h28; addr_set[2] = 8'h08;

        repeat (3) tick();
        check_reset_state("rst_hold");
        rst_n = 1'b1;
        repeat (2) tick();
        check_reset_state("rst_release");

        // Single entry: address then data strobe on chip 0.
        w0 = n_writes;
        push(0, 8'h20, 8'hC7, 1);
        check("push_level", level, 1);
        check("push_not_idle", idle, 0);
        wait_idle("single_idle");
        check("single_writes", n_writes - w0, 2);

        // Repeated address on chip 1: second entry issues only its data strobe.
        w0 = n_writes;
        push(1, 8'h28, 8'h4A, 1);
        push(1, 8'h28, 8'h4B, 1);
        wait_idle("cache_idle");
        check("cache_writes", n_writes - w0, 3);

        // Fill while chip 0 is busy, the extra push is dropped, then drain in order.
        chip_busy = 2'b01;
        for (int i = 0; i < DEPTH; i++)
            push(0, 8'h10 + 8'(i % 2), 8'($urandom), 1);
        check("full_level", level, DEPTH);
        check("full_ready", host_ready, 0);
        push(0, 8'h55, 8'hAA, 0);
        check("full_drop_level", level, DEPTH);
        chip_busy = '0;
        wait_idle("fill_idle");
        check("fill_ready_back", host_ready, 1);

        // Flush during the first entry's data wait.
        chip_busy = 2'b01;
        for (int i = 0; i < 5; i++)
            push(0, 8'h40 + 8'(i), 8'h60 + 8'(i), 1);
        check("flush_pre_level", level, 5);
        chip_busy = '0;
        n = 0;
        while (q.size() > 4 && n < 500) begin
            tick();
            n++;
        end
        check("flush_first_done", q.size(), 4);
        chip_busy = 2'b01;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (phase && q.size() != 0) begin
            h = q[0];
            q.delete();
            q.push_back(h);
        end else begin
            q.delete();
        end
        cvalid = '0;
        check("flush_level_inflight", level, 1);
        chip_busy = '0;
        wait_idle("flush_idle");
        check("flush_level", level, 0);
        w0 = n_writes;
        push(0, 8'h40, 8'h99, 1);
        wait_idle("post_flush_idle");
        check("post_flush_writes", n_writes - w0, 2);

        // Randomized traffic with random busy.
        for (int c = 0; c < 400; c++) begin
            chip_busy = {2{1'b0}} | {NCHIP'($urandom_range(0, 5) == 0), NCHIP'(0)} >> 0;
            chip_busy[0] = ($urandom_range(0, 5) == 0);
            chip_busy[1] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0 && q.size() < DEPTH - 2) begin
                check("ready_on_push", host_ready, 1);
                push(int'($urandom_range(0, NCHIP - 1)), addr_set[$urandom_range(0, 2)],
                     8'($urandom), 1);
            end else begin
                tick();
            end
        end
        chip_busy = '0;
        wait_idle("random_idle");
        check("random_err", err, 0);

        // Reset during a data strobe releases the bus at once.
        push(0, 8'h77, 8'h55, 1);
        n = 0;
        while (!(!wr_n && a0) && n < 500) begin
            tick();
            n++;
        end
        check("dstb_reached", 32'(!wr_n && a0), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_cs_n", cs_n, {NCHIP{1'b1}});
        check("async_wr_n", wr_n, 1);
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_reset_state("mid_rst");
        w0 = n_writes;
        push(1, 8'h28, 8'h99, 1);
        wait_idle("after_rst_idle");
        check("after_rst_writes", n_writes - w0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
